// File: rtl/cpu_ext_host.sv
// Host-side initiator for the CPU external IMEM/DMEM ports: valid/ready command and response
// channels, plus a gated CPU enable for a programmed run length.
module cpu_ext_host #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  input  logic             run_start,
  input  logic [CNT_W-1:0] run_len,
  input  logic             run_stop,
  output logic             busy,
  output logic             run_done,
  output logic             cpu_enable,
  output logic [31:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  input  logic [31:0]      rdata_ext,
  output logic [31:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [31:0]      wdata_ext_2,
  input  logic [31:0]      rdata_ext_2
);

  typedef enum logic [2:0] {StIdle, StWrite, StReadWait, StResp, StRun} state_e;

  localparam logic [1:0] LatLast = 2'(RD_LAT);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       lat_q, lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             done_q, done_d;

  logic cmd_fire;
  logic port_act;
  logic imem_act;
  logic dmem_act;

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A command accepted this cycle takes priority over run_start.
        if (cmd_fire) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          lat_d   = 2'd0;
          state_d = cmd_op[1] ? StReadWait : StWrite;
        end else if (run_start) begin
          if (run_len == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = run_len;
            state_d = StRun;
          end
        end
      end
      StWrite: state_d = StIdle;
      StReadWait: begin
        if (lat_q == LatLast) begin
          rsp_data_d = op_q[0] ? rdata_ext_2 : rdata_ext;
          state_d    = StResp;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      StRun: begin
        if (run_stop || (cnt_q == CNT_W'(1))) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_q      <= 2'd0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      done_q     <= done_d;
    end
  end

  // Ext ports carry traffic only in the WRITE cycle or the first READ_WAIT cycle.
  assign port_act = (state_q == StWrite) || ((state_q == StReadWait) && (lat_q == 2'd0));
  assign imem_act = port_act && !op_q[0];
  assign dmem_act = port_act && op_q[0];

  assign wen_ext     = imem_act && (state_q == StWrite);
  assign ren_ext     = imem_act && (state_q == StReadWait);
  assign addr_ext    = imem_act ? addr_q : '0;
  assign wdata_ext   = wen_ext ? wdata_q : '0;
  assign wen_ext_2   = dmem_act && (state_q == StWrite);
  assign ren_ext_2   = dmem_act && (state_q == StReadWait);
  assign addr_ext_2  = dmem_act ? addr_q : '0;
  assign wdata_ext_2 = wen_ext_2 ? wdata_q : '0;

  assign rsp_valid  = (state_q == StResp);
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != StIdle);
  assign cpu_enable = (state_q == StRun);
  assign run_done   = done_q;

endmodule

// File: tb/tb_cpu_ext_host.sv
// Scoreboarded bench for cpu_ext_host: reference memory model predicts writes and read data,
// monitors compare ext-port traffic and responses; run-length behaviour checked per run.
module tb_cpu_ext_host;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic run_start = 1'b0, run_stop = 1'b0;
  logic [CNT_W-1:0] run_len = '0;
  logic busy, run_done, cpu_enable;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] rdata_ext = '0, rdata_ext_2 = '0;

  cpu_ext_host #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .run_start(run_start), .run_len(run_len), .run_stop(run_stop),
    .busy(busy), .run_done(run_done), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        port;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wrq[$];
  logic [31:0] rspq[$];
  logic [31:0] ref_i[logic [31:0]];
  logic [31:0] ref_d[logic [31:0]];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          rr_mode = 1;  // 0: rsp_ready low, 1: high, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic port, input logic [31:0] a);
    if (port) return ref_d.exists(a) ? ref_d[a] : 32'h0;
    return ref_i.exists(a) ? ref_i[a] : 32'h0;
  endfunction

  // Memories attached to the ext ports; read data appears one cycle after ren.
  logic [31:0] mem_i [64];
  logic [31:0] mem_d [64];
  initial for (int k = 0; k < 64; k++) begin mem_i[k] = '0; mem_d[k] = '0; end
  always @(posedge clk) begin
    if (wen_ext)   mem_i[addr_ext[7:2]]   <= wdata_ext;
    if (wen_ext_2) mem_d[addr_ext_2[7:2]] <= wdata_ext_2;
    if (ren_ext)   rdata_ext   <= mem_i[addr_ext[7:2]];
    if (ren_ext_2) rdata_ext_2 <= mem_d[addr_ext_2[7:2]];
  end

  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = (rr_mode == 1) ? 1'b1 : (rr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Write-port monitor and port invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (wen_ext || wen_ext_2) begin
        if (wrq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_write: got wen=%b/%b, expected no write", wen_ext, wen_ext_2);
        end else begin
          wr_t e;
          e = wrq.pop_front();
          check("wr_port", 32'(wen_ext_2), 32'(e.port));
          check("wr_addr", e.port ? addr_ext_2 : addr_ext, e.addr);
          check("wr_data", e.port ? wdata_ext_2 : wdata_ext, e.data);
        end
      end
      if (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)
        check("strobe_onehot", 32'($countones({wen_ext, ren_ext, wen_ext_2, ren_ext_2})), 1);
      if (cpu_enable) begin
        check("run_ports_idle", 32'({wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                                     |addr_ext, |addr_ext_2, |wdata_ext, |wdata_ext_2}), 0);
        check("run_cmd_ready", 32'(cmd_ready), 0);
        check("run_busy", 32'(busy), 1);
      end
    end
  end

  // Response monitor: pops on handshake, checks hold while stalled.
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  always @(negedge clk) begin
    if (rst) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        check("rsp_hold_valid", 32'(rsp_valid), 1);
        check("rsp_hold_data", rsp_data, hold_d);
      end
      if (rsp_valid && rsp_ready) begin
        hold_v <= 1'b0;
        if (rspq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_rsp: got 0x%08h, expected no response", rsp_data);
        end else begin
          check("rsp_data", rsp_data, rspq.pop_front());
        end
      end else begin
        hold_v <= rsp_valid;
        hold_d <= rsp_data;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    bit rdy;
    int t;
    if (!op[1]) begin
      if (op[0]) ref_d[addr] = wdata;
      else       ref_i[addr] = wdata;
      wrq.push_back(wr_t'{port: op[0], addr: addr, data: wdata});
    end else begin
      rspq.push_back(ref_rd(op[0], addr));
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    rdy = 1'b0;
    t = 0;
    while (!rdy && t < 100) begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      t++;
    end
    #1;
    cmd_valid = 1'b0;
    if (!rdy) begin
      n_cmp++; n_fail++;
      $display("FAIL cmd_timeout: got cmd_ready=0 for 100 cycles, expected acceptance");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((wrq.size() != 0 || rspq.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_wrq", 32'(wrq.size()), 0);
    check("drain_rspq", 32'(rspq.size()), 0);
  endtask

  task automatic run(input int len, input int stop);
    int t, en, done, done_at, busy_after, exp, iters;
    bit stopped;
    exp = (stop > 0 && stop < len) ? stop : len;
    iters = exp + 6;
    en = 0; done = 0; done_at = 0; busy_after = 1; stopped = 1'b0;
    @(negedge clk);
    t = 0;
    while (busy && t < 300) begin @(negedge clk); t++; end
    run_start = 1'b1;
    run_len = CNT_W'(len);
    @(negedge clk);
    run_start = 1'b0;
    for (int i = 1; i <= iters; i++) begin
      if (cpu_enable) en++;
      if (run_done) begin done++; done_at = i; end
      if (i == exp + 1) busy_after = int'(busy);
      if (stop > 0 && en == stop && !stopped) begin
        run_stop = 1'b1;
        stopped = 1'b1;
      end
      @(negedge clk);
      run_stop = 1'b0;
    end
    check("run_en_cycles", 32'(en), 32'(exp));
    check("run_done_count", 32'(done), 1);
    check("run_done_at", 32'(done_at), 32'(exp + 1));
    check("run_busy_after", 32'(busy_after), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cycle_cmd_ready", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_strobes", 32'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 0);
    check("rst_addr_ext", addr_ext | addr_ext_2, 0);
    check("rst_wdata_ext", wdata_ext | wdata_ext_2, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_status", 32'({cpu_enable, busy, run_done}), 0);

    // Directed transfers.
    issue(2'b00, 32'h4, 32'hDEADBEEF);
    issue(2'b01, 32'h10, 32'h12345678);
    issue(2'b11, 32'h10, 32'h0);
    drain();

    // Response backpressure.
    rr_mode = 0;
    issue(2'b10, 32'h4, 32'h0);
    begin
      int t;
      t = 0;
      while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_data", rsp_data, 32'hDEADBEEF);
      check("bp_cmd_ready", 32'(cmd_ready), 0);
    end
    rr_mode = 1;
    drain();

    // Runs.
    run(7, 0);
    run(100, 3);
    run(0, 0);

    // Reset in the middle of a read.
    issue(2'b11, 32'h10, 32'h0);
    rst = 1'b1;
    rspq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_rsp_valid", 32'(rsp_valid), 0);
      check("rst_mid_status", 32'({busy, cpu_enable}), 0);
    end
    issue(2'b01, 32'h20, 32'hCAFEF00D);
    issue(2'b11, 32'h20, 32'h0);
    drain();

    // Randomised traffic with occasional runs.
    rr_mode = 2;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        int len;
        drain();
        len = int'($urandom_range(0, 12));
        run(len, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len)) : 0);
      end else begin
        issue(2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)) << 2, $urandom);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
